// File: rtl/ad9361_spi_pkg.sv
// Shared types and instruction-word layout for the AD9361-format SPI responder.
package ad9361_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSTR,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } state_t;

    localparam int INSTR_RW_BIT = 15;
    localparam int INSTR_NB_MSB = 14;
    localparam int INSTR_NB_LSB = 12;
    localparam int INSTR_LEN    = 16;

endpackage

// File: rtl/spi_in_sync.sv
// Synchronizes the asynchronous SPI pins into clk and derives one-cycle edge pulses
// for sclk and csn from the synchronized copies.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_sclk,
    input  logic spi_csn,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csn_rise,
    output logic csn_fall,
    output logic mosi
);

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] csn_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic                   sclk_q;
    logic                   csn_q;

    // csn chain resets high so leaving reset never fabricates a select edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_ff <= '0;
            csn_ff  <= '1;
            mosi_ff <= '0;
            sclk_q  <= 1'b0;
            csn_q   <= 1'b1;
        end else begin
            sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], spi_sclk};
            csn_ff  <= {csn_ff[SYNC_STAGES-2:0], spi_csn};
            mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], spi_mosi};
            sclk_q  <= sclk_ff[SYNC_STAGES-1];
            csn_q   <= csn_ff[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_ff[SYNC_STAGES-1] & ~sclk_q;
    assign sclk_fall = ~sclk_ff[SYNC_STAGES-1] & sclk_q;
    assign csn_rise  = csn_ff[SYNC_STAGES-1] & ~csn_q;
    assign csn_fall  = ~csn_ff[SYNC_STAGES-1] & csn_q;
    assign mosi      = mosi_ff[SYNC_STAGES-1];

endmodule

// File: rtl/ad9361_spi_responder.sv
// AD9361-format SPI responder: decodes a 16-bit instruction plus 1..8 data bytes and
// turns them into strobed accesses on an external 8-bit register space.
module ad9361_spi_responder
    import ad9361_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_csn,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              xfer_done,
    output logic              xfer_abort
);

    logic sclk_rise, sclk_fall, csn_rise, csn_fall, mosi_s;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .spi_sclk  (spi_sclk),
        .spi_csn   (spi_csn),
        .spi_mosi  (spi_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csn_rise  (csn_rise),
        .csn_fall  (csn_fall),
        .mosi      (mosi_s)
    );

    state_t                 state, state_n;
    logic [3:0]             bit_cnt;
    logic [2:0]             byte_cnt;
    logic [2:0]             nb;
    logic [INSTR_LEN-2:0]   shift_in;
    logic [7:0]             shift_out;
    logic [ADDR_W-1:0]      addr;
    logic                   rd_pend;
    logic                   done_arm;

    assign reg_addr = addr;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // shift_in holds the first 15 instruction bits when the 16th arrives on mosi_s
    always_comb begin
        state_n = state;
        if (csn_rise) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (csn_fall) state_n = ST_INSTR;
                ST_INSTR: if (sclk_rise && bit_cnt == 4'(INSTR_LEN - 1))
                              state_n = shift_in[INSTR_RW_BIT-1] ? ST_WDATA : ST_RDATA;
                ST_WDATA,
                ST_RDATA: if (sclk_rise && bit_cnt == 4'd7 && byte_cnt == nb)
                              state_n = ST_DONE;
                default:  state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            nb          <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            addr        <= '0;
            rd_pend     <= 1'b0;
            done_arm    <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            reg_wdata   <= '0;
            xfer_done   <= 1'b0;
            xfer_abort  <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            xfer_abort <= 1'b0;
            xfer_done  <= done_arm;
            done_arm   <= 1'b0;
            rd_pend    <= reg_rd_en;
            if (rd_pend) shift_out <= reg_rdata;
            // step to the next (descending) address once the current strobe is out
            if (reg_wr_en || reg_rd_en) addr <= addr - ADDR_W'(1);

            if (csn_rise) begin
                if (state != ST_IDLE) begin
                    xfer_abort  <= (state != ST_DONE);
                    spi_miso_oe <= 1'b0;
                    spi_miso    <= 1'b0;
                    bit_cnt     <= '0;
                    byte_cnt    <= '0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (csn_fall) begin
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                            shift_in <= '0;
                        end
                    end
                    ST_INSTR: begin
                        if (sclk_rise) begin
                            shift_in <= {shift_in[INSTR_LEN-3:0], mosi_s};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'(INSTR_LEN - 1)) begin
                                bit_cnt   <= '0;
                                nb        <= shift_in[INSTR_NB_MSB-1:INSTR_NB_LSB-1];
                                addr      <= {shift_in[ADDR_W-2:0], mosi_s};
                                reg_rd_en <= ~shift_in[INSTR_RW_BIT-1];
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sclk_rise) begin
                            shift_in <= {shift_in[INSTR_LEN-3:0], mosi_s};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt   <= '0;
                                byte_cnt  <= byte_cnt + 3'd1;
                                reg_wr_en <= 1'b1;
                                reg_wdata <= {shift_in[6:0], mosi_s};
                                done_arm  <= (byte_cnt == nb);
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (sclk_fall) begin
                            spi_miso_oe <= 1'b1;
                            spi_miso    <= shift_out[7];
                            shift_out   <= {shift_out[6:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt  <= '0;
                                byte_cnt <= byte_cnt + 3'd1;
                                if (byte_cnt == nb) xfer_done <= 1'b1;
                                else                reg_rd_en <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (sclk_fall) spi_miso <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
